projectile_ctl: RTL

Per-turn projectile flight engine. It sits directly downstream of the wind controller and consumes its `wind` value (0..100, 50 = calm). On `fire` it integrates a fixed-point ballistic trajectory once per video frame, applying gravity and wind drift, and detects target hit, ground impact or off-screen exit. It then holds an impact phase and emits the `next_turn` pulse that advances the wind controller and the turn logic.

---
 rtl/projectile_ctl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/projectile_ctl.sv
// Per-turn projectile flight engine: fixed-point ballistic step per frame, hit/miss detection,
// impact hold and next_turn handoff. Define WIND_DRIFT_EN to let the wind value drift vx.
module projectile_ctl #(
  parameter int unsigned FRAC_BITS   = 4,
  parameter int unsigned GRAVITY     = 2,
  parameter int unsigned WIND_SHIFT  = 3,
  parameter int unsigned GROUND_Y    = 600,
  parameter int unsigned SCREEN_W    = 1024,
  parameter int unsigned HOLD_FRAMES = 30,
  parameter int unsigned MAX_FRAMES  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        fire,
  input  logic        dir,
  input  logic [10:0] start_x,
  input  logic [10:0] start_y,
  input  logic [7:0]  vx0,
  input  logic [7:0]  vy0,
  input  logic [6:0]  wind,
  input  logic [10:0] tgt_x_min,
  input  logic [10:0] tgt_x_max,
  input  logic [10:0] tgt_y_min,
  input  logic [10:0] tgt_y_max,
  output logic [10:0] proj_x,
  output logic [10:0] proj_y,
  output logic        proj_active,
  output logic        impact,
  output logic        hit,
  output logic        miss,
  output logic        next_turn
);

  localparam int PW    = 12 + FRAC_BITS;
  localparam int IW    = PW + 1 - FRAC_BITS;
  localparam int CntW  = $clog2(MAX_FRAMES + 1);
  localparam int HoldW = $clog2(HOLD_FRAMES + 1);

  localparam logic signed [IW-1:0] GroundI   = IW'(GROUND_Y);
  localparam logic signed [IW-1:0] ScreenI   = IW'(SCREEN_W);
  localparam logic signed [PW-1:0] GroundFix = PW'(GROUND_Y * (2 ** FRAC_BITS));
  localparam logic signed [11:0]   GravV     = 12'(GRAVITY);

  typedef enum logic [1:0] {StIdle, StFlight, StHold} state_e;

  state_e                 state_q, state_d;
  logic signed [PW-1:0]   px_q, px_d, py_q, py_d;
  logic signed [11:0]     vx_q, vx_d, vy_q, vy_d;
  logic signed [7:0]      wind_acc_q, wind_acc_d;
  logic [CntW-1:0]        frame_cnt_q, frame_cnt_d;
  logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                   hit_q, hit_d, miss_q, miss_d, next_turn_q, next_turn_d;

  logic signed [PW:0]     px_nxt, py_nxt;
  logic signed [IW-1:0]   x_int, y_int;
  logic signed [11:0]     vx_mag, vy_mag, wind_ext;
  logic                   in_box, off_screen;

  // Velocities clamp symmetrically so a runaway wind/gravity cannot wrap the sign.
  function automatic logic signed [11:0] sat_add(input logic signed [11:0] a,
                                                 input logic signed [11:0] b);
    logic signed [12:0] s;
    s = $signed({a[11], a}) + $signed({b[11], b});
    if (s > 13'sd2047) begin
      return 12'sd2047;
    end else if (s < -13'sd2047) begin
      return -12'sd2047;
    end
    return s[11:0];
  endfunction

`ifdef WIND_DRIFT_EN
  logic signed [7:0] wind_off;
  assign wind_off = $signed({1'b0, wind}) - 8'sd50;
  assign wind_acc_d = (state_q == StIdle && fire) ? (wind_off >>> WIND_SHIFT) : wind_acc_q;
`else
  logic unused_wind;
  assign unused_wind = ^wind;
  assign wind_acc_d  = '0;
`endif

  assign vx_mag   = $signed({4'b0000, vx0});
  assign vy_mag   = $signed({4'b0000, vy0});
  assign wind_ext = {{4{wind_acc_q[7]}}, wind_acc_q};

  // One bit of headroom so the screen/ground tests see the true sum before truncation.
  assign px_nxt = $signed({px_q[PW-1], px_q}) + $signed({{(PW-11){vx_q[11]}}, vx_q});
  assign py_nxt = $signed({py_q[PW-1], py_q}) + $signed({{(PW-11){vy_q[11]}}, vy_q});
  assign x_int  = $signed(px_nxt[PW:FRAC_BITS]);
  assign y_int  = $signed(py_nxt[PW:FRAC_BITS]);

  assign in_box = (x_int >= $signed({2'b00, tgt_x_min})) && (x_int <= $signed({2'b00, tgt_x_max}))
               && (y_int >= $signed({2'b00, tgt_y_min})) && (y_int <= $signed({2'b00, tgt_y_max}));
  assign off_screen = (x_int < 0) || (x_int >= ScreenI);

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    frame_cnt_d = frame_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    next_turn_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fire) begin
          px_d        = $signed({1'b0, start_x, {FRAC_BITS{1'b0}}});
          py_d        = $signed({1'b0, start_y, {FRAC_BITS{1'b0}}});
          vx_d        = dir ? -vx_mag : vx_mag;
          vy_d        = -vy_mag;
          frame_cnt_d = '0;
          state_d     = StFlight;
        end
      end
      StFlight: begin
        if (frame_tick) begin
          px_d        = px_nxt[PW-1:0];
          py_d        = py_nxt[PW-1:0];
          vx_d        = sat_add(vx_q, wind_ext);
          vy_d        = sat_add(vy_q, GravV);
          frame_cnt_d = frame_cnt_q + 1'b1;
          hold_cnt_d  = '0;
          if (in_box) begin
            hit_d   = 1'b1;
            state_d = StHold;
          end else if (y_int >= GroundI) begin
            miss_d  = 1'b1;
            py_d    = GroundFix;
            state_d = StHold;
          end else if (off_screen || frame_cnt_d == CntW'(MAX_FRAMES)) begin
            miss_d  = 1'b1;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (frame_tick) begin
          if (hold_cnt_q == HoldW'(HOLD_FRAMES - 1)) begin
            next_turn_d = 1'b1;
            hold_cnt_d  = '0;
            state_d     = StIdle;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      px_q        <= '0;
      py_q        <= '0;
      vx_q        <= '0;
      vy_q        <= '0;
      wind_acc_q  <= '0;
      frame_cnt_q <= '0;
      hold_cnt_q  <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      next_turn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      wind_acc_q  <= wind_acc_d;
      frame_cnt_q <= frame_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      next_turn_q <= next_turn_d;
    end
  end

  assign proj_x      = px_q[FRAC_BITS +: 11];
  assign proj_y      = py_q[FRAC_BITS +: 11];
  assign proj_active = (state_q == StFlight);
  assign impact      = (state_q == StHold);
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign next_turn   = next_turn_q;

endmodule
